// File: rtl/usr_serial_tx_controller.sv
// -----------------------------------------------------------------------------
// usr_serial_tx_controller
//
// Sequencer that sits directly in front of a universal shift register (USR).
// It accepts one parallel word per valid/ready handshake. It then parallel-loads
// the word into the USR and shifts it out one bit per clock, LSB-first or
// MSB-first. It also generates the strobes a downstream consumer uses to sample
// the USR serial output.
//
// Handshake: a word is transferred on a rising edge where Tx_Valid_In and
// Tx_Ready_Out are both high. Tx_Ready_Out is high in IDLE and in the last bit
// cycle of SHIFT, and is suppressed whenever Abort_In is high. The producer
// holds Tx_Data_In/Tx_Dir_In stable while Tx_Valid_In is high and the word has
// not yet been accepted.
//
// Ports
//   Clk_In, Reset_In         clock, asynchronous active-low reset
//   Tx_Data_In/Dir/Valid     word to send, bit order, qualifier
//   Tx_Ready_Out             a word can be accepted this cycle
//   Abort_In                 drop the word in flight, return to IDLE
//   USR_Mode_Out             0 load, 1 shift right, 2 shift left, 3 hold
//   USR_Parallel_Data_Out    word presented to the USR parallel input
//   USR_Serial_Fill_Out      constant FILL_BIT for the vacated USR end
//   Serial_Valid_Out         USR serial output carries a valid bit
//   Serial_Bit_Index_Out     index of that bit, in transmit order
//   Serial_Dir_Out           direction of the word in flight
//   Done_Out                 last bit of the word is presented
//   Busy_Out                 controller is in LOAD or SHIFT
//   State_Dbg_Out            FSM state (0 IDLE, 1 LOAD, 2 SHIFT)
// -----------------------------------------------------------------------------
module usr_serial_tx_controller #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic        FILL_BIT   = 1'b0
) (
   input  logic                          Clk_In,
   input  logic                          Reset_In,
   input  logic [DATA_WIDTH-1:0]         Tx_Data_In,
   input  logic                          Tx_Dir_In,
   input  logic                          Tx_Valid_In,
   output logic                          Tx_Ready_Out,
   input  logic                          Abort_In,
   output logic [1:0]                    USR_Mode_Out,
   output logic [DATA_WIDTH-1:0]         USR_Parallel_Data_Out,
   output logic                          USR_Serial_Fill_Out,
   output logic                          Serial_Valid_Out,
   output logic [$clog2(DATA_WIDTH)-1:0] Serial_Bit_Index_Out,
   output logic                          Serial_Dir_Out,
   output logic                          Done_Out,
   output logic                          Busy_Out,
   output logic [1:0]                    State_Dbg_Out
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   localparam logic [1:0] MODE_LOAD  = 2'd0;
   localparam logic [1:0] MODE_RIGHT = 2'd1;
   localparam logic [1:0] MODE_LEFT  = 2'd2;
   localparam logic [1:0] MODE_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  dir_q, dir_d;

   logic cnt_last;
   logic tx_ready;
   logic accept;

   assign cnt_last = (cnt_q == CNT_LAST);
   // The last shift cycle also accepts, so back-to-back words lose only the LOAD cycle.
   assign tx_ready = ~Abort_In & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & cnt_last));
   assign accept   = Tx_Valid_In & tx_ready;

   // State register
   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         dir_q   <= dir_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      dir_d   = dir_q;
      if (Abort_In) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
            ST_SHIFT: begin
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = accept ? ST_LOAD : ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      if (accept) begin
         hold_d = Tx_Data_In;
         dir_d  = Tx_Dir_In;
      end
   end

   // Output logic
   always_comb begin
      USR_Mode_Out     = MODE_HOLD;
      Serial_Valid_Out = 1'b0;
      Done_Out         = 1'b0;
      Busy_Out         = 1'b0;
      case (state_q)
         ST_LOAD: begin
            USR_Mode_Out = MODE_LOAD;
            Busy_Out     = 1'b1;
         end
         ST_SHIFT: begin
            Busy_Out         = 1'b1;
            Serial_Valid_Out = 1'b1;
            Done_Out         = cnt_last;
            // The last bit is already at the serial output; no further shift is needed.
            if (!cnt_last) USR_Mode_Out = dir_q ? MODE_LEFT : MODE_RIGHT;
         end
         default: ;
      endcase
      // Abort freezes the USR and withdraws the bit strobes in the same cycle.
      if (Abort_In) begin
         USR_Mode_Out     = MODE_HOLD;
         Serial_Valid_Out = 1'b0;
         Done_Out         = 1'b0;
      end
   end

   assign Tx_Ready_Out          = tx_ready;
   assign USR_Parallel_Data_Out = hold_q;
   assign USR_Serial_Fill_Out   = FILL_BIT;
   // cnt is zero outside SHIFT, so the index reads 0 when idle.
   assign Serial_Bit_Index_Out  = cnt_q;
   assign Serial_Dir_Out        = dir_q;
   assign State_Dbg_Out         = state_q;

endmodule

// File: tb/tb_usr_serial_tx_controller.sv
module tb_usr_serial_tx_controller;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [W-1:0]  tx_data;
   logic          tx_dir;
   logic          tx_valid;
   logic          tx_ready;
   logic          abort;
   logic [1:0]    usr_mode;
   logic [W-1:0]  usr_pdata;
   logic          usr_fill;
   logic          ser_valid;
   logic [4:0]    ser_idx;
   logic          ser_dir;
   logic          done;
   logic          busy;
   logic [1:0]    state_dbg;

   usr_serial_tx_controller #(.DATA_WIDTH(W), .FILL_BIT(1'b0)) dut (
      .Clk_In                (clk),
      .Reset_In              (rst_n),
      .Tx_Data_In            (tx_data),
      .Tx_Dir_In             (tx_dir),
      .Tx_Valid_In           (tx_valid),
      .Tx_Ready_Out          (tx_ready),
      .Abort_In              (abort),
      .USR_Mode_Out          (usr_mode),
      .USR_Parallel_Data_Out (usr_pdata),
      .USR_Serial_Fill_Out   (usr_fill),
      .Serial_Valid_Out      (ser_valid),
      .Serial_Bit_Index_Out  (ser_idx),
      .Serial_Dir_Out        (ser_dir),
      .Done_Out              (done),
      .Busy_Out              (busy),
      .State_Dbg_Out         (state_dbg)
   );

   // Behavioural USR driven by the controller outputs.
   logic [W-1:0] usr_q = '0;
   always @(posedge clk) begin
      case (usr_mode)
         2'd0: usr_q <= usr_pdata;
         2'd1: usr_q <= {usr_fill, usr_q[W-1:1]};
         2'd2: usr_q <= {usr_q[W-2:0], usr_fill};
         default: ;
      endcase
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic         valid;
      logic         dir;
      logic         abort;
      logic [W-1:0] data;
      logic         rdy;
      logic [1:0]   mode;
      logic         sv;
      logic [4:0]   idx;
      logic         done;
      logic         busy;
      logic         chk_pd;
      logic [W-1:0] pd;
      logic         wdir;
      logic         ebit;
   } vec_t;

   vec_t vecs[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One IDLE cycle with the given inputs.
   task automatic add_idle(input logic valid, input logic dir, input logic ab, input logic [W-1:0] data);
      vec_t v;
      v = '{default: 0};
      v.valid = valid; v.dir = dir; v.abort = ab; v.data = data;
      v.rdy = ~ab; v.mode = 2'd3;
      vecs.push_back(v);
   endtask

   // LOAD plus SHIFT cycles of a word already accepted. nv/nd/ndir are the
   // producer inputs held during the word; abort_idx < 0 means no abort.
   task automatic add_word(input logic [W-1:0] word, input logic wdir, input logic nv,
                           input logic [W-1:0] nd, input logic ndir, input int abort_idx);
      vec_t v;
      v = '{default: 0};
      v.valid = nv; v.data = nd; v.dir = ndir;
      v.mode = 2'd0; v.busy = 1'b1; v.chk_pd = 1'b1; v.pd = word;
      vecs.push_back(v);
      for (int i = 0; i < W; i++) begin
         v = '{default: 0};
         v.valid = nv; v.data = nd; v.dir = ndir;
         v.busy = 1'b1; v.idx = i[4:0]; v.wdir = wdir;
         v.ebit = wdir ? word[W-1-i] : word[i];
         if (i == abort_idx) begin
            v.valid = 1'b0; v.abort = 1'b1; v.mode = 2'd3;
            vecs.push_back(v);
            return;
         end
         v.sv   = 1'b1;
         v.mode = (i == W-1) ? 2'd3 : (wdir ? 2'd2 : 2'd1);
         v.done = (i == W-1);
         v.rdy  = (i == W-1);
         vecs.push_back(v);
      end
   endtask

   // Called at a falling edge: drive inputs, check outputs, advance one cycle.
   task automatic apply_vec(input int n, input vec_t v);
      logic ser_bit;
      tx_valid = v.valid; tx_dir = v.dir; abort = v.abort; tx_data = v.data;
      #1;
      chk($sformatf("v%0d ready", n), tx_ready, v.rdy);
      chk($sformatf("v%0d mode", n), usr_mode, v.mode);
      chk($sformatf("v%0d ser_valid", n), ser_valid, v.sv);
      chk($sformatf("v%0d index", n), ser_idx, v.idx);
      chk($sformatf("v%0d done", n), done, v.done);
      chk($sformatf("v%0d busy", n), busy, v.busy);
      if (v.chk_pd) chk($sformatf("v%0d pdata", n), usr_pdata, v.pd);
      if (v.sv) begin
         ser_bit = v.wdir ? usr_q[W-1] : usr_q[0];
         chk($sformatf("v%0d ser_dir", n), ser_dir, v.wdir);
         chk($sformatf("v%0d ser_bit", n), ser_bit, v.ebit);
      end
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " ready"}, tx_ready, 1'b1);
      chk({tag, " mode"}, usr_mode, 2'd3);
      chk({tag, " pdata"}, usr_pdata, '0);
      chk({tag, " ser_valid"}, ser_valid, 1'b0);
      chk({tag, " index"}, ser_idx, 5'd0);
      chk({tag, " ser_dir"}, ser_dir, 1'b0);
      chk({tag, " done"}, done, 1'b0);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " fill"}, usr_fill, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b1; tx_valid = 1'b0; tx_dir = 1'b0; abort = 1'b0; tx_data = '0;
      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      add_idle(0, 0, 0, '0);
      // LSB-first word
      add_idle(1, 0, 0, 32'hA5A5_0F0F);
      add_word(32'hA5A5_0F0F, 0, 0, '0, 0, -1);
      add_idle(0, 0, 0, '0);
      // MSB-first word
      add_idle(1, 1, 0, 32'h8000_0001);
      add_word(32'h8000_0001, 1, 0, '0, 0, -1);
      add_idle(0, 0, 0, '0);
      // back-to-back, valid held high throughout the first word
      add_idle(1, 0, 0, 32'hFFFF_FFFF);
      add_word(32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 0, -1);
      add_word(32'h0000_0000, 0, 0, '0, 0, -1);
      add_idle(0, 0, 0, '0);
      // abort at index 10
      add_idle(1, 0, 0, 32'h1234_5678);
      add_word(32'h1234_5678, 0, 0, '0, 0, 10);
      add_idle(0, 0, 0, '0);
      // abort and valid together in IDLE: nothing captured
      add_idle(1, 0, 1, 32'hCAFE_F00D);
      add_idle(0, 0, 0, '0);
      add_idle(0, 0, 0, '0);

      foreach (vecs[n]) apply_vec(n, vecs[n]);

      // Reset at index 5 of a word while the next word is being offered.
      vecs.delete();
      add_idle(1, 1, 0, 32'h5555_AAAA);
      add_word(32'h5555_AAAA, 1, 1, 32'hDEAD_BEEF, 0, -1);
      for (int n = 0; n < 7; n++) apply_vec(1000 + n, vecs[n]);
      tx_valid = 1'b1; tx_dir = 1'b0; abort = 1'b0; tx_data = 32'hDEAD_BEEF;
      #1;
      chk("pre-reset index", ser_idx, 5'd5);
      chk("pre-reset ser_dir", ser_dir, 1'b1);
      #1 rst_n = 1'b0;
      #1 check_reset("mid-word reset");
      @(negedge clk);
      rst_n = 1'b1;

      vecs.delete();
      add_idle(1, 0, 0, 32'hDEAD_BEEF);
      add_word(32'hDEAD_BEEF, 0, 0, '0, 0, -1);
      add_idle(0, 0, 0, '0);
      foreach (vecs[n]) apply_vec(2000 + n, vecs[n]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
